rr_arbiter8: RTL and testbench

- 8-requester round-robin arbiter that produces the registered 3-bit grant index feeding the team's 3-to-8 one-hot decoder.
- The decoder expands gnt_idx into the one-hot grant bus.
- Grant is held until the owner signals done or drops its request.
- The rotating pointer guarantees fairness: no requester waits more than 7 grants.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 27 ++
 rtl/rr_arbiter8.sv | 121 ++++++++++++
 tb/tb_rr_arbiter8.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and index helper for the 8-way round-robin arbiter.
// TIMEOUT_CYC and HOLD_CNT_W only matter when ARB_TIMEOUT_EN is defined.
package arb_pkg;

    localparam int N_REQ       = 8;
    localparam int IDX_W       = 3;
    localparam int TIMEOUT_CYC = 16;
    localparam int HOLD_CNT_W  = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Wraps 7 -> 0 through the natural 3-bit overflow.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker: first set bit of mask scanning start, start+1, ... mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate right so that bit 'start' lands at position 0; for start=0 the left shift is 8 and yields 0.
    assign rot = (mask >> start) | (mask << (4'd8 - {1'b0, start}));

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
    end

    assign any = |mask;
    assign idx = start + off;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered grant index; grant held until done or request drop.
// Optional forced release after TIMEOUT_CYC held cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] idx_n;
    logic             valid_n;
    logic             timeout_n;
    logic             new_grant;

    logic [N_REQ-1:0] owner_oh;
    logic             nat_rel;
    logic             force_rel;
    logic             rel;

    logic [N_REQ-1:0] pick_mask;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    assign owner_oh = N_REQ'(1) << gnt_idx;
    assign nat_rel  = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt;

    assign force_rel = (hold_cnt == HOLD_CNT_W'(TIMEOUT_CYC - 1)) & ~nat_rel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (new_grant) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    assign rel = (state == GRANT) & (nat_rel | force_rel);

    // One picker serves both paths; in GRANT the owner is masked so it cannot re-win on its own release.
    assign pick_mask  = (state == GRANT) ? (req & ~owner_oh) : req;
    assign pick_start = (state == GRANT) ? next_idx(gnt_idx) : ptr;

    rr_pick8 u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_n   = state;
        idx_n     = gnt_idx;
        valid_n   = gnt_valid;
        ptr_n     = ptr;
        timeout_n = 1'b0;
        new_grant = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    idx_n     = pick_idx;
                    valid_n   = 1'b1;
                    state_n   = GRANT;
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_n     = next_idx(gnt_idx);
                    timeout_n = force_rel;
                    if (pick_any) begin
                        idx_n     = pick_idx;
                        new_grant = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            ptr       <= ptr_n;
            timeout   <= timeout_n;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, fairness, wrap, drop-release, simultaneous events, hold/timeout.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_arbiter8 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] idx, input logic vld);
        chk({tag, ".idx"}, {5'd0, gnt_idx}, {5'd0, idx});
        chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, vld});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, vld});
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #12;
        chk_grant("reset", 3'd0, 1'b0);
        chk("reset.timeout", {7'd0, timeout}, 8'h00);

        // Single request after reset, then async reset mid-grant.
        step();
        rst = 1'b0;
        req = 8'h10;
        step();
        chk_grant("single", 3'd4, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk_grant("async_rst", 3'd0, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk_grant("rst_release", 3'd4, 1'b1);

        // Fairness from ptr=0: all requesting, done every third cycle.
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
        req = 8'hFF;
        step();
        chk_grant("rr0", 3'd0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            step();
            chk_grant("rr_hold", 3'((k - 1) % 8), 1'b1);
            done = 1'b1;
            step();
            done = 1'b0;
            chk_grant("rr_next", 3'(k % 8), 1'b1);
        end

        // Wrap: owner 0 drops, 7 wins; then 0 (not 7) after wrap; then 7 again.
        req = 8'h80;
        step();
        chk_grant("wrap7", 3'd7, 1'b1);
        req  = 8'h81;
        done = 1'b1;
        step();
        chk_grant("wrap0", 3'd0, 1'b1);
        step();
        done = 1'b0;
        chk_grant("wrap7b", 3'd7, 1'b1);

        // Drop-release to IDLE keeps last index.
        req = 8'h04;
        step();
        chk_grant("to2", 3'd2, 1'b1);
        req = 8'h00;
        step();
        chk_grant("drop_idle", 3'd2, 1'b0);

        // Owner re-raises with done: masked, 6 wins.
        req = 8'h08;
        step();
        chk_grant("own3", 3'd3, 1'b1);
        req  = 8'h48;
        done = 1'b1;
        step();
        done = 1'b0;
        chk_grant("reraise", 3'd6, 1'b1);
        req = 8'h00;
        step();
        chk_grant("idle6", 3'd6, 1'b0);
        done = 1'b1;
        step();
        step();
        done = 1'b0;
        chk_grant("done_idle", 3'd6, 1'b0);

        // done and drop together: a single release (ptr 7 -> pick 0, then 1).
        req = 8'h01;
        step();
        chk_grant("own0", 3'd0, 1'b1);
        req  = 8'h02;
        done = 1'b1;
        step();
        done = 1'b0;
        chk_grant("single_rel", 3'd1, 1'b1);
        req = 8'h03;
        step();
        step();
        chk_grant("no_preempt", 3'd1, 1'b1);

        // Owner 1 never releases with req=06.
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
        req = 8'h06;
        step();
        chk_grant("hold1", 3'd1, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= 15; c++) begin
            step();
            chk("to_wait.idx", {5'd0, gnt_idx}, 8'h01);
            chk("to_wait.timeout", {7'd0, timeout}, 8'h00);
        end
        step();
        chk_grant("to_fire", 3'd2, 1'b1);
        chk("to_fire.timeout", {7'd0, timeout}, 8'h01);
        step();
        chk("to_pulse_end", {7'd0, timeout}, 8'h00);
        chk_grant("to_after", 3'd2, 1'b1);
`else
        for (int c = 1; c <= 100; c++) begin
            step();
            chk("hold.idx", {5'd0, gnt_idx}, 8'h01);
            chk("hold.timeout", {7'd0, timeout}, 8'h00);
        end
        chk_grant("hold_end", 3'd1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
